// File: rtl/tt_vector_pkg.sv
// Shared types and width helpers for the Tiny Tapeout vector player.
// Module parameters feed the helpers so all counters size from one place.
package tt_vector_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RST,
        RUN,
        DRAIN,
        FIN
    } state_t;

    localparam int DEF_WIDTH      = 8;
    localparam int DEF_DEPTH      = 16;
    localparam int DEF_CAP_DEPTH  = 16;
    localparam int DEF_RST_CYCLES = 4;

    // Pointer width for a power-of-two store; never narrower than one bit.
    function automatic int ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Occupancy width: one extra bit so a completely full store is representable.
    function automatic int cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

    function automatic int rst_cnt_w(input int cycles);
        return (cycles > 1) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/tt_vector_player_fifo.sv
// Synchronous FIFO for captured DUT responses.
// A push into a full FIFO succeeds only when a pop happens in the same cycle.
module tt_sync_fifo
    import tt_vector_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_CAP_DEPTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = ptr_w(DEPTH);
    localparam int CW = cnt_w(DEPTH);
    localparam logic [CW-1:0] FULL_C = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == FULL_C);
    assign empty = (count == '0);
    assign rd_en = pop && !empty;
    assign wr_en = push && (!full || rd_en);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];

endmodule

// File: rtl/tt_vector_player.sv
// Drives a Tiny Tapeout project's pins from a loaded vector memory:
// reset phase, one vector per cycle, then captures uo_out into a FIFO.
module tt_vector_player
    import tt_vector_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int CAP_DEPTH  = DEF_CAP_DEPTH,
    parameter int RST_CYCLES = DEF_RST_CYCLES
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load_valid,
    input  logic [WIDTH-1:0]       load_data,
    output logic                   load_ready,
    input  logic                   clear,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [WIDTH-1:0]       dut_ui_in,
    output logic                   dut_rst_n,
    output logic                   dut_ena,
    input  logic [WIDTH-1:0]       dut_uo_out,
    output logic                   cap_valid,
    output logic [WIDTH-1:0]       cap_data,
    input  logic                   cap_ready,
    output logic                   overflow,
    output logic [$clog2(DEPTH):0] vec_count
);

    localparam int AW  = ptr_w(DEPTH);
    localparam int CW  = cnt_w(DEPTH);
    localparam int RCW = rst_cnt_w(RST_CYCLES);
    localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);
    localparam logic [RCW-1:0] RST_C   = RCW'(RST_CYCLES);

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] vec_mem [DEPTH];
    logic [AW-1:0]    idx;
    logic [RCW-1:0]   rst_cnt;
    logic             ran_once;
    logic             idx_last;
    logic             rst_last;
    logic             load_fire;
    logic             cap_push;
    logic             cap_drop;
    logic             cap_full;
    logic             cap_empty;

    // idx is zero-extended so the compare never wraps when vec_count == DEPTH.
    assign idx_last  = (({1'b0, idx} + CW'(1)) == vec_count);
    assign rst_last  = (rst_cnt == RCW'(1));
    assign load_fire = load_valid && load_ready && !clear;
    assign cap_drop  = cap_push && cap_full && !cap_ready;
    assign cap_valid = !cap_empty;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n    = state;
        busy       = (state != IDLE);
        done       = 1'b0;
        dut_ena    = 1'b0;
        dut_rst_n  = ran_once;
        load_ready = 1'b0;
        cap_push   = 1'b0;
        case (state)
            IDLE: begin
                load_ready = (vec_count < DEPTH_C);
                if (start) state_n = IDLE == IDLE ? RST : IDLE;
            end
            RST: begin
                dut_ena   = 1'b1;
                dut_rst_n = 1'b0;
                if (rst_last) state_n = (vec_count == '0) ? FIN : RUN;
            end
            RUN: begin
                dut_ena  = 1'b1;
                // The response to vector k-1 is on uo_out while vector k is driven.
                cap_push = (idx != '0);
                if (idx_last) state_n = DRAIN;
            end
            DRAIN: begin
                dut_ena  = 1'b1;
                cap_push = 1'b1;
                state_n  = FIN;
            end
            FIN: begin
                done    = 1'b1;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rst_cnt   <= '0;
            idx       <= '0;
            ran_once  <= 1'b0;
            dut_ui_in <= '0;
            vec_count <= '0;
            overflow  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rst_cnt  <= RST_C;
                        ran_once <= 1'b1;
                    end
                    if (clear)          vec_count <= '0;
                    else if (load_fire) vec_count <= vec_count + CW'(1);
                end
                RST: begin
                    rst_cnt <= rst_cnt - RCW'(1);
                    if (state_n == RUN) begin
                        idx       <= '0;
                        dut_ui_in <= vec_mem[0];
                    end
                end
                RUN: begin
                    if (!idx_last) begin
                        idx       <= idx + AW'(1);
                        dut_ui_in <= vec_mem[idx + AW'(1)];
                    end
                end
                FIN:     dut_ui_in <= '0;
                default: dut_ui_in <= dut_ui_in;
            endcase
            if (state == IDLE && start) overflow <= 1'b0;
            else if (cap_drop)          overflow <= 1'b1;
        end
    end

    // Vector memory is data only: it survives rst and clear.
    always_ff @(posedge clk) begin
        if (load_fire) vec_mem[vec_count[AW-1:0]] <= load_data;
    end

    tt_sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (CAP_DEPTH)
    ) u_cap_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cap_push),
        .push_data (dut_uo_out),
        .pop       (cap_ready),
        .pop_data  (cap_data),
        .full      (cap_full),
        .empty     (cap_empty)
    );

endmodule
